// File: rtl/mem_responder.sv
// Data-memory responder: request/ready bus slave backed by a word RAM and a
// small I/O page (LED register, prescaled timer with compare interrupt).
module mem_responder #(
   parameter int RAM_AW    = 10,
   parameter int TIMER_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] e_addr_bus,
   input  logic [15:0] e_data,
   input  logic        mem_re,
   input  logic        mem_we,
   output logic [15:0] e_mem_bus,
   output logic        mem_ready,
   output logic [7:0]  leds,
   output logic        timer_irq
);

   localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

   localparam logic [15:0] ADDR_LED  = 16'hFF00;
   localparam logic [15:0] ADDR_CNT  = 16'hFF01;
   localparam logic [15:0] ADDR_CMP  = 16'hFF02;
   localparam logic [15:0] ADDR_STAT = 16'hFF03;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state;
   logic [15:0]       addr_q;
   logic [15:0]       wdata_q;
   logic              op_we;
   logic [15:0]       ram [2**RAM_AW];
   logic [PW-1:0]     presc;
   logic [15:0]       count;
   logic [15:0]       compare;
   logic              pending;

   logic              ram_hit;
   logic [RAM_AW-1:0] ram_idx;
   logic              do_wr;
   logic              ram_we;
   logic              led_we;
   logic              cmp_we;
   logic              stat_clr;
   logic              tick;
   logic [15:0]       count_nxt;
   logic              set_ev;
   logic [15:0]       io_rdata;

   // A write is dropped if reset coincides with its commit edge.
   assign ram_hit   = (({16'b0, addr_q} >> RAM_AW) == 32'd0);
   assign ram_idx   = addr_q[RAM_AW-1:0];
   assign do_wr     = (state == BUSY) && op_we && !rst;
   assign ram_we    = do_wr && ram_hit;
   assign led_we    = do_wr && (addr_q == ADDR_LED);
   assign cmp_we    = do_wr && (addr_q == ADDR_CMP);
   assign stat_clr  = do_wr && (addr_q == ADDR_STAT) && wdata_q[0];
   assign tick      = (presc == PRESC_MAX);
   assign count_nxt = count + 16'd1;
   assign set_ev    = tick && (count_nxt == compare);
   assign timer_irq = pending;

   always_comb begin
      io_rdata = 16'h0000;
      case (addr_q)
         ADDR_LED:  io_rdata = {8'h00, leds};
         ADDR_CNT:  io_rdata = count;
         ADDR_CMP:  io_rdata = compare;
         ADDR_STAT: io_rdata = {15'b0, pending};
         default:   io_rdata = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_idx] <= wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && (mem_we || mem_re)) begin
         addr_q  <= e_addr_bus;
         wdata_q <= e_data;
         op_we   <= mem_we;
      end
   end

   // Bus FSM: IDLE accepts, BUSY performs the access, RESP strobes ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_ready <= 1'b0;
         e_mem_bus <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               mem_ready <= 1'b0;
               if (mem_we || mem_re) begin
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (!op_we) begin
                  e_mem_bus <= ram_hit ? ram[ram_idx] : io_rdata;
               end
               mem_ready <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // I/O page registers and the free-running timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         leds    <= 8'h00;
         presc   <= '0;
         count   <= 16'h0000;
         compare <= 16'hFFFF;
         pending <= 1'b0;
      end else begin
         if (led_we) begin
            leds <= wdata_q[7:0];
         end
         if (cmp_we) begin
            compare <= wdata_q;
         end
         if (tick) begin
            presc <= '0;
            count <= count_nxt;
         end else begin
            presc <= presc + 1'b1;
         end
         if (set_ev) begin
            pending <= 1'b1;
         end else if (stat_clr) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM and I/O accesses, timer interrupt,
// reset mid-access and back-to-back requests.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] addr = 16'h0, wdata = 16'h0;
   logic        re = 1'b0, we = 1'b0;
   logic [15:0] bus;
   logic        ready;
   logic [7:0]  leds;
   logic        irq;
   logic [15:0] addr1 = 16'h0, wdata1 = 16'h0;
   logic        re1 = 1'b0, we1 = 1'b0;
   logic [15:0] bus1;
   logic        ready1;
   logic [7:0]  leds1;
   logic        irq1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rst_cyc = 0;

   mem_responder #(.RAM_AW(10), .TIMER_DIV(2)) dut (
      .clk(clk), .rst(rst), .e_addr_bus(addr), .e_data(wdata),
      .mem_re(re), .mem_we(we), .e_mem_bus(bus), .mem_ready(ready),
      .leds(leds), .timer_irq(irq));

   mem_responder #(.RAM_AW(10), .TIMER_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .e_addr_bus(addr1), .e_data(wdata1),
      .mem_re(re1), .mem_we(we1), .e_mem_bus(bus1), .mem_ready(ready1),
      .leds(leds1), .timer_irq(irq1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rst_cyc = cyc;
   endtask

   task automatic bus_op(input bit sel, input bit w, input bit r,
                         input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output int lat);
      @(posedge clk); #1;
      if (sel) begin addr1 = a; wdata1 = d; we1 = w; re1 = r; end
      else     begin addr  = a; wdata  = d; we  = w; re  = r; end
      lat = 0;
      rd  = 16'h0000;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (sel ? ready1 : ready) begin
            lat = k;
            rd  = sel ? bus1 : bus;
         end
      end
      we = 1'b0; re = 1'b0; we1 = 1'b0; re1 = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", ready); end
      n_cmp++; if (bus !== 16'h0000) begin n_bad++; $display("FAIL rst_bus got %h want 0000", bus); end
      n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL rst_leds got %h want 00", leds); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b want 0", irq); end
   endtask

   task automatic test_ram();
      logic [15:0] rd; int lat;
      bus_op(0, 1, 0, 16'h0005, 16'h1234, rd, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ram_wr_lat got %0d want 2", lat); end
      n_cmp++; if (bus !== 16'h0000) begin n_bad++; $display("FAIL ram_wr_bus got %h want 0000", bus); end
      bus_op(0, 0, 1, 16'h0005, 16'h0000, rd, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ram_rd_lat got %0d want 2", lat); end
      n_cmp++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL ram_rd got %h want 1234", rd); end
      bus_op(0, 0, 1, 16'hFF02, 16'h0000, rd, lat);
      n_cmp++; if (rd !== 16'hFFFF) begin n_bad++; $display("FAIL cmp_rst got %h want ffff", rd); end
   endtask

   task automatic test_io();
      logic [15:0] rd; int lat;
      bus_op(0, 1, 0, 16'hFF00, 16'h12A5, rd, lat);
      n_cmp++; if (leds !== 8'hA5) begin n_bad++; $display("FAIL led_wr got %h want a5", leds); end
      bus_op(0, 0, 1, 16'hFF00, 16'h0000, rd, lat);
      n_cmp++; if (rd !== 16'h00A5) begin n_bad++; $display("FAIL led_rd got %h want 00a5", rd); end
      bus_op(0, 0, 1, 16'h8000, 16'h0000, rd, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL unmap_lat got %0d want 2", lat); end
      n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL unmap_rd got %h want 0000", rd); end
      bus_op(0, 1, 0, 16'h8000, 16'h7777, rd, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL unmap_wr_lat got %0d want 2", lat); end
   endtask

   task automatic test_both_high();
      logic [15:0] rd; int lat;
      bus_op(0, 0, 1, 16'h0005, 16'h0000, rd, lat);
      bus_op(0, 1, 1, 16'h0003, 16'hBEEF, rd, lat);
      n_cmp++; if (bus !== 16'h1234) begin n_bad++; $display("FAIL both_bus got %h want 1234", bus); end
      bus_op(0, 0, 1, 16'h0003, 16'h0000, rd, lat);
      n_cmp++; if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL both_rd got %h want beef", rd); end
   endtask

   task automatic test_timer();
      logic [15:0] rd; int lat;
      do_reset();
      addr = 16'hFF02; wdata = 16'h0003; we = 1'b1;
      addr1 = 16'hFF02; wdata1 = 16'h0003; we1 = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL t1_irq_early got %b want 0", irq1); end
      @(posedge clk); #1;
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL cmp_wr_ready got %b want 1", ready); end
      we = 1'b0; we1 = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (irq1 !== 1'b1) begin n_bad++; $display("FAIL t1_irq_at3 got %b want 1", irq1); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL t2_irq_r3 got %b want 0", irq); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL t2_irq_r5 got %b want 0", irq); end
      @(posedge clk); #1;
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL t2_irq_r6 got %b want 1", irq); end
      bus_op(0, 0, 1, 16'hFF03, 16'h0000, rd, lat);
      n_cmp++; if (rd !== 16'h0001) begin n_bad++; $display("FAIL stat_rd got %h want 0001", rd); end
      bus_op(0, 0, 1, 16'hFF01, 16'h0000, rd, lat);
      n_cmp++; if (rd !== 16'h0005) begin n_bad++; $display("FAIL cnt_rd got %h want 0005", rd); end
      bus_op(0, 1, 0, 16'hFF01, 16'h0100, rd, lat);
      bus_op(0, 0, 1, 16'hFF01, 16'h0000, rd, lat);
      n_cmp++; if (rd !== 16'h0008) begin n_bad++; $display("FAIL cnt_ro got %h want 0008", rd); end
      bus_op(0, 1, 0, 16'hFF03, 16'h0001, rd, lat);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clr got %b want 0", irq); end
      bus_op(1, 1, 0, 16'hFF03, 16'h0001, rd, lat);
      n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL t1_irq_clr got %b want 0", irq1); end
      while (irq1 !== 1'b1 && (cyc - rst_cyc) < 70000) begin
         @(posedge clk); #1;
      end
      n_cmp++; if (irq1 !== 1'b1 || (cyc - rst_cyc) !== 65539) begin
         n_bad++; $display("FAIL wrap_irq got irq=%b at %0d want 1 at 65539", irq1, cyc - rst_cyc);
      end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL t2_irq_stay got %b want 0", irq); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd; int lat;
      bus_op(0, 1, 0, 16'hFF00, 16'h003C, rd, lat);
      bus_op(0, 1, 0, 16'h0007, 16'h0001, rd, lat);
      bus_op(0, 0, 1, 16'h0007, 16'h0000, rd, lat);
      @(posedge clk); #1;
      addr = 16'h0007; wdata = 16'h5555; we = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; we = 1'b0;
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready got %b want 0", ready); end
      n_cmp++; if (bus !== 16'h0000) begin n_bad++; $display("FAIL mid_bus got %h want 0000", bus); end
      n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL mid_leds got %h want 00", leds); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_irq got %b want 0", irq); end
      @(posedge clk); #1;
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready2 got %b want 0", ready); end
      bus_op(0, 0, 1, 16'h0007, 16'h0000, rd, lat);
      n_cmp++; if (rd !== 16'h0001) begin n_bad++; $display("FAIL mid_rd got %h want 0001", rd); end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      addr = 16'h0005; re = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         n_cmp++; if (ready !== (k % 3 == 2)) begin
            n_bad++; $display("FAIL b2b_ready k=%0d got %b want %b", k, ready, (k % 3 == 2));
         end
         if (k % 3 == 2) begin
            n_cmp++; if (bus !== 16'h1234) begin n_bad++; $display("FAIL b2b_data k=%0d got %h want 1234", k, bus); end
         end
      end
      re = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stop got %b want 0", ready); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_io();
      test_both_high();
      test_timer();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
